// File: rtl/clock_controller_pkg.sv
// Shared encodings for the CPU clock sequencer: FSM states and mode values.
package clock_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PULSE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/clock_controller_if.sv
// Control/status bundle between the board-level driver (master) and the clock sequencer (slave).
interface clock_controller_if #(parameter int DIV_W = 16);
    logic             mode;
    logic             push;
    logic             hlt;
    logic [DIV_W-1:0] half_period;
    logic             cpu_clk;
    logic             cpu_clk_rise;
    logic             halted;
    logic [1:0]       state;

    modport master (output mode, push, hlt, half_period,
                    input  cpu_clk, cpu_clk_rise, halted, state);
    modport slave  (input  mode, push, hlt, half_period,
                    output cpu_clk, cpu_clk_rise, halted, state);
endinterface

// File: rtl/push_debouncer.sv
// Synchronizes and debounces the raw step button; emits a one-cycle step_req on each accepted press.
module push_debouncer #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    output logic deb,
    output logic step_req
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d, deb_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = sync2_q;
            else                              cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
        end else begin
            sync1_q   <= push;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
        end
    end

    assign deb      = deb_q;
    assign step_req = deb_q & ~deb_dly_q;

endmodule

// File: rtl/clock_controller.sv
// CPU clock sequencer: astable divider, debounced single-step pulses and halt, all from one system clock.
module clock_controller
    import clock_controller_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int DEB_CYCLES   = 4,
    parameter int PULSE_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    clock_controller_if.slave bus
);
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    state_e           state_q, state_d;
    logic             cpu_clk_q, cpu_clk_d;
    logic             rise_q, rise_d;
    logic             halted_q, halted_d;
    logic [DIV_W-1:0] div_q, div_d, h_m1;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             deb, step_req, leave, div_tc;

    push_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.push),
        .deb      (deb),
        .step_req (step_req)
    );

    // A half period of 0 behaves as 1; >= keeps a shrinking half_period from wrapping the count.
    assign h_m1   = (bus.half_period == '0) ? '0 : bus.half_period - 1'b1;
    assign div_tc = (div_q >= h_m1);
    assign leave  = bus.hlt | (bus.mode == MODE_STEP);

    always_comb begin
        state_d   = state_q;
        cpu_clk_d = cpu_clk_q;
        div_d     = div_q;
        pcnt_d    = pcnt_q;
        case (state_q)
            ST_IDLE: begin
                cpu_clk_d = 1'b0;
                if (bus.hlt) begin
                    state_d = ST_HALT;
                end else if (bus.mode == MODE_RUN) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end else if (step_req) begin
                    state_d   = ST_PULSE;
                    cpu_clk_d = 1'b1;
                    pcnt_d    = '0;
                end
            end
            ST_RUN: begin
                // A low phase may be abandoned at once; a high phase always completes.
                if (leave && !cpu_clk_q) begin
                    state_d = bus.hlt ? ST_HALT : ST_IDLE;
                    div_d   = '0;
                end else if (div_tc) begin
                    cpu_clk_d = ~cpu_clk_q;
                    div_d     = '0;
                    if (cpu_clk_q && leave) state_d = bus.hlt ? ST_HALT : ST_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_PULSE: begin
                if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
                    cpu_clk_d = 1'b0;
                    state_d   = ST_IDLE;
                    pcnt_d    = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: cpu_clk_d = 1'b0;
        endcase
    end

    assign rise_d   = cpu_clk_d & ~cpu_clk_q;
    assign halted_d = (state_d == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cpu_clk_q <= 1'b0;
            rise_q    <= 1'b0;
            halted_q  <= 1'b0;
            div_q     <= '0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cpu_clk_q <= cpu_clk_d;
            rise_q    <= rise_d;
            halted_q  <= halted_d;
            div_q     <= div_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign bus.cpu_clk      = cpu_clk_q;
    assign bus.cpu_clk_rise = rise_q;
    assign bus.halted       = halted_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_clock_controller.sv
// Randomized scoreboard bench: stimulus predicts each cpu_clk high phase (rise edge, width); a monitor checks them.
module tb_clock_controller;
    localparam int DEB = 4;
    localparam int PUL = 2;

    typedef struct {
        int edge_n;
        int width;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    bit   measuring = 0;
    int   rise_cyc, cur_w;

    clock_controller_if #(.DIV_W(16)) bus ();

    clock_controller #(.DIV_W(16), .DEB_CYCLES(DEB), .PULSE_CYCLES(PUL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every high phase must match the oldest prediction in start edge and length.
    always @(negedge clk) begin
        if (measuring && !bus.cpu_clk) begin
            check("high_width", cyc - rise_cyc, cur_w);
            measuring = 0;
        end
        if (bus.cpu_clk_rise) begin
            check("rise_has_clk", int'(bus.cpu_clk), 1);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rise: got rise at %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rise_edge", cyc, e.edge_n);
                cur_w     = e.width;
                rise_cyc  = cyc;
                measuring = 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, int'(bus.state), 0);
        check({tag, "_cpu_clk"}, int'(bus.cpu_clk), 0);
        check({tag, "_halted"}, int'(bus.halted), 0);
    endtask

    // Press with optional sub-threshold bounce, a held level with a short dropout, then a clean release.
    task automatic do_press();
        int nb, k;
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
            bus.push = 1'b1; wait_n($urandom_range(1, DEB - 1));
            bus.push = 1'b0; wait_n($urandom_range(1, 3));
        end
        bus.push = 1'b1;
        k = cyc + 1;
        exp_q.push_back('{k + 2 + DEB, PUL});
        wait_n(DEB + PUL + 3 + $urandom_range(0, 6));
        if ($urandom_range(0, 1) == 1) begin
            bus.push = 1'b0; wait_n($urandom_range(1, DEB - 1));
            bus.push = 1'b1; wait_n(DEB + 2);
        end
        bus.push = 1'b0;
        wait_n(DEB + 3 + $urandom_range(0, 5));
    endtask

    task automatic do_glitch();
        bus.push = 1'b1; wait_n($urandom_range(1, DEB - 1));
        bus.push = 1'b0; wait_n(DEB + 4);
    endtask

    task automatic reset_to_idle();
        rst = 1'b1; bus.mode = 1'b1; bus.hlt = 1'b0; bus.push = 1'b0;
        wait_n(2);
        rst = 1'b0;
        wait_n(2);
    endtask

    // kind: 0 mode in high phase, 1 mode in low phase, 2 hlt in high, 3 hlt in low, 4 reset in high
    task automatic run_astable(input int hp, input int kind, input bit from_reset);
        int h, e, n, r, s, t;
        h = (hp == 0) ? 1 : hp;
        bus.half_period = 16'(hp);
        bus.mode = 1'b0;
        if (from_reset) begin
            rst = 1'b1; wait_n(2); rst = 1'b0;
        end
        e = cyc + 1;
        n = $urandom_range(1, 3);
        r = e + h + 2 * h * (n - 1);
        for (int i = 0; i < n; i++) begin
            if (kind == 4 && i == n - 1) begin
                t = r + $urandom_range(1, h - 1);
                exp_q.push_back('{e + h + 2 * h * i, t - r});
            end else begin
                exp_q.push_back('{e + h + 2 * h * i, h});
            end
        end
        if (kind == 4) begin
            while (cyc != t - 1) @(negedge clk);
            rst = 1'b1; bus.mode = 1'b1;
            wait_n(1);
            rst = 1'b0;
            wait_n(3);
            check_idle("rst_trunc");
            return;
        end
        s = (kind == 0 || kind == 2) ? r + 1 + $urandom_range(0, h - 1)
                                     : r + h + 1 + $urandom_range(0, h - 1);
        while (cyc != s - 1) @(negedge clk);
        if (kind >= 2) bus.hlt = 1'b1;
        else           bus.mode = 1'b1;
        wait_n(2 * h + 4);
        if (kind < 2) begin
            check_idle("mode_exit");
            wait_n(2 * h + 2);
            check("mode_exit_stay", int'(bus.state), 0);
        end else begin
            check("halt_state", int'(bus.state), 3);
            check("halt_flag", int'(bus.halted), 1);
            check("halt_clk", int'(bus.cpu_clk), 0);
            bus.push = 1'b1; bus.mode = 1'b1; wait_n(DEB + 6);
            bus.mode = 1'b0; wait_n(3);
            bus.push = 1'b0; wait_n(DEB + 4);
            check("halt_sticky", int'(bus.state), 3);
            check("halt_sticky_flag", int'(bus.halted), 1);
            reset_to_idle();
            check_idle("halt_reset");
        end
    endtask

    initial begin
        rst = 1'b1; bus.mode = 1'b1; bus.push = 1'b0; bus.hlt = 1'b0; bus.half_period = 16'd3;
        wait_n(2);
        check("reset_state", int'(bus.state), 0);
        check("reset_clk", int'(bus.cpu_clk), 0);
        check("reset_rise", int'(bus.cpu_clk_rise), 0);
        check("reset_halted", int'(bus.halted), 0);
        rst = 1'b0;
        wait_n(10);
        check_idle("post_reset");

        for (int i = 0; i < 6; i++) do_press();
        for (int i = 0; i < 3; i++) do_glitch();
        check_idle("after_steps");

        bus.hlt = 1'b1; wait_n(1); bus.hlt = 1'b0; wait_n(2);
        check("idle_hlt_state", int'(bus.state), 3);
        check("idle_hlt_flag", int'(bus.halted), 1);
        reset_to_idle();

        run_astable(3, 0, 1'b0);
        run_astable(0, 1, 1'b0);
        run_astable(3, 2, 1'b0);
        run_astable(2, 0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            int hp, kind;
            hp   = $urandom_range(0, 6);
            kind = $urandom_range(0, 4);
            if (kind == 4 && hp < 2) kind = 0;
            run_astable(hp, kind, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) do_press();
        end

        wait_n(20);
        check("queue_drained", exp_q.size(), 0);
        check("no_open_phase", int'(measuring), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
